// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, sequencer state type and 4-bit ripple helper
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum[3:0]} of a 4-bit ripple-carry add.
    function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [3:0] s;
        logic       c;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
        end
        return {c, s};
    endfunction

endpackage

// File: rtl/carryskip8.sv
// rtl/carryskip8.sv - 8-bit carry-skip adder built from two 4-bit ripple blocks
module carryskip8
    import adder_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] sum,
    output logic       co
);

    logic [7:0] p;
    logic [4:0] lo;
    logic [4:0] hi;
    logic       c4;

    assign p  = a ^ b;
    assign lo = rca4(a[3:0], b[3:0], ci);
    // A fully-propagating block passes its carry-in straight through.
    assign c4 = (&p[3:0]) ? ci : lo[4];
    assign hi = rca4(a[7:4], b[7:4], c4);
    assign co = (&p[7:4]) ? c4 : hi[4];
    assign sum = {hi[3:0], lo[3:0]};

endmodule

// File: rtl/carryskip_seq_ctrl.sv
// rtl/carryskip_seq_ctrl.sv - byte-serial wide add/sub sequencer around one carryskip8
module carryskip_seq_ctrl
    import adder_pkg::*;
#(
    parameter int N_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [BYTE_W*N_BYTES-1:0] a,
    input  logic [BYTE_W*N_BYTES-1:0] b,
    input  logic                    ci,
    input  logic                    sub,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [BYTE_W*N_BYTES-1:0] sum,
    output logic                    co,
    output logic                    ovf
);

    localparam int W     = BYTE_W * N_BYTES;
    localparam int IDX_W = $clog2(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    state_t state, state_nxt;

    logic [W-1:0]      opa;
    logic [W-1:0]      opb;
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] byte_a;
    logic [BYTE_W-1:0] byte_b;
    logic [BYTE_W-1:0] byte_s;
    logic              byte_co;
    logic              accept;
    logic              last;

    assign byte_a = opa[idx*BYTE_W +: BYTE_W];
    assign byte_b = opb[idx*BYTE_W +: BYTE_W];
    assign last   = (idx == LAST_IDX);
    assign accept = start_valid & start_ready;

    carryskip8 u_adder (
        .a   (byte_a),
        .b   (byte_b),
        .ci  (carry),
        .sum (byte_s),
        .co  (byte_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == IDLE) & ~rst;
        res_valid   = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                opa   <= a;
                // Subtraction is A + ~B + 1.
                opb   <= sub ? ~b : b;
                carry <= sub ? 1'b1 : ci;
                idx   <= '0;
            end else if (state == RUN) begin
                sum[idx*BYTE_W +: BYTE_W] <= byte_s;
                carry <= byte_co;
                if (last) begin
                    co  <= byte_co;
                    ovf <= (opa[W-1] == opb[W-1]) & (byte_s[BYTE_W-1] != opa[W-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_carryskip_seq_ctrl.sv
// tb/tb_carryskip_seq_ctrl.sv - scoreboard bench for carryskip_seq_ctrl
module tb_carryskip_seq_ctrl;

    localparam int N = 4;
    localparam int W = 8 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic seen = 1'b0;

    always #5 clk = ~clk;

    carryskip_seq_ctrl #(.N_BYTES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .ci          (ci),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .co          (co),
        .ovf         (ovf)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Monitor: one comparison set per result presented.
    always @(negedge clk) begin
        if (!rst && res_valid && !seen) begin
            exp_t e;
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("co",  64'(co),  64'(e.co));
                check("ovf", 64'(ovf), 64'(e.ovf));
            end
        end else if (!res_valid) begin
            seen = 1'b0;
        end
    end

    task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci, input logic tsub);
        bit ok = 0;
        a = ta; b = tb_; ci = tci; sub = tsub;
        start_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (start_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci, input logic tsub,
                          input logic [W-1:0] esum, input logic eco, input logic eovf);
        int lat = 0;
        sb_q.push_back('{sum: esum, co: eco, ovf: eovf});
        accept_op(ta, tb_, tci, tsub);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(N));
        if (res_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", 64'(start_ready), 64'd0);
        check("rst_res_valid",   64'(res_valid),   64'd0);
        check("rst_sum",         64'(sum),         64'd0);
        check("rst_co_ovf",      64'({co, ovf}),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_start_ready", 64'(start_ready), 64'd1);

        run_op(32'h00000005, 32'h0000000A, 1'b1, 1'b0, 32'h00000010, 1'b0, 1'b0);
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op(32'd100,      32'd200,      1'b0, 1'b1, 32'hFFFFFF9C, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);

        // Backpressure with competing start pulses.
        res_ready = 1'b0;
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            a = 32'hDEAD0000 + k; b = 32'h1; sub = 1'b0;
            start_valid = k[0] ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            check("bp_res_valid",   64'(res_valid),   64'd1);
            check("bp_sum",         64'(sum),         64'h23456789);
            check("bp_co_ovf",      64'({co, ovf}),   64'd0);
            check("bp_start_ready", 64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle",  64'(start_ready), 64'd1);
        check("bp_release_valid", 64'(res_valid),   64'd0);
        @(posedge clk); #1;
        check("bp_no_extra_op",   64'(res_valid),   64'd0);

        // Reset in the second RUN cycle discards the operation.
        accept_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_res_valid",   64'(res_valid),   64'd0);
        check("mid_rst_sum",         64'(sum),         64'd0);
        check("mid_rst_start_ready", 64'(start_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_start_ready", 64'(start_ready), 64'd1);
        run_op(32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0, 1'b0);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
